// File: rtl/pc_utils_pkg.sv
// Shared types and default widths for the gated pulse counter.
package pc_utils_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } pc_state_e;

  localparam int PC_CNT_W  = 16;
  localparam int PC_GATE_W = 24;

endpackage

// File: rtl/gate_timer.sv
// Wrap-around window timer: counts 0..GATE_CYCLES-1 while run is high,
// flags the final window cycle, and sits at 0 while run is low.
module gate_timer #(
  parameter int GATE_CYCLES = 1000,
  parameter int GATE_W      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic last
);

  logic [GATE_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == GATE_W'(GATE_CYCLES - 1));
  assign last   = w_last;

  // Advance one step per running cycle, wrapping after the last window cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || !run || w_last) r_cnt <= '0;
    else                          r_cnt <= r_cnt + GATE_W'(1);
  end

endmodule

// File: rtl/pulse_gate_counter.sv
// Gated event counter: totals pulses over fixed back-to-back windows and
// hands each total to a valid/ready consumer, flagging dropped results.
module pulse_gate_counter
  import pc_utils_pkg::*;
#(
  parameter int CNT_W       = PC_CNT_W,
  parameter int GATE_CYCLES = 1000,
  parameter int GATE_W      = PC_GATE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             drop_err,
  output logic             busy
);

  pc_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_acc;
  logic             r_acc_sat;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             r_valid;
  logic             r_drop;

  logic             w_run;
  logic             w_last;
  logic             w_done;
  logic             w_hs;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_total;
  logic             w_total_sat;

  // Timer only runs while a window is active and still enabled; an abort or
  // the final cycle of a non-continued window brings it back to 0.
  assign w_run = (r_state == GATE) && enable;

  gate_timer #(
    .GATE_CYCLES (GATE_CYCLES),
    .GATE_W      (GATE_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .last  (w_last)
  );

  // The final window cycle completes even if enable drops in that cycle.
  assign w_done = (r_state == GATE) && w_last;
  assign w_hs   = r_valid && count_ready;

  // Saturating running total including this cycle's pulse.
  assign w_sum       = {1'b0, r_acc} + {{CNT_W{1'b0}}, pulse};
  assign w_total     = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign w_total_sat = r_acc_sat | w_sum[CNT_W];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: enable alone decides whether a window runs next cycle,
  // both to start from IDLE and to continue or abort from GATE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = enable ? GATE : IDLE;
      GATE:    w_state_nxt = enable ? GATE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator: cleared outside a window, on abort and at window end.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == IDLE) || w_last || !enable) begin
      r_acc     <= '0;
      r_acc_sat <= 1'b0;
    end else begin
      r_acc     <= w_total;
      r_acc_sat <= w_total_sat;
    end
  end

  // Result register and handshake: load on window end when free or being
  // drained this cycle, otherwise record a drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_done && (!r_valid || w_hs)) begin
        r_count <= w_total;
        r_sat   <= w_total_sat;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (r_state == IDLE)            r_drop <= 1'b0;
      else if (w_done && r_valid && !w_hs) r_drop <= 1'b1;
    end
  end

  assign count       = r_count;
  assign sat         = r_sat;
  assign count_valid = r_valid;
  assign drop_err    = r_drop;
  assign busy        = (r_state == GATE);

endmodule

// File: tb/tb_pulse_gate_counter.sv
// Directed bench: table of 10-cycle windows plus hand sequences for
// backpressure, abort, reset and saturation.
module tb_pulse_gate_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse, enable, count_ready;
  logic [7:0] count;
  logic       sat, count_valid, drop_err, busy;

  logic       s_pulse, s_enable, s_ready;
  logic [3:0] s_count;
  logic       s_sat, s_valid, s_drop, s_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_gate_counter #(.CNT_W(8), .GATE_CYCLES(10), .GATE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .enable(enable),
    .count(count), .sat(sat), .count_valid(count_valid),
    .count_ready(count_ready), .drop_err(drop_err), .busy(busy)
  );

  pulse_gate_counter #(.CNT_W(4), .GATE_CYCLES(20), .GATE_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .pulse(s_pulse), .enable(s_enable),
    .count(s_count), .sat(s_sat), .count_valid(s_valid),
    .count_ready(s_ready), .drop_err(s_drop), .busy(s_busy)
  );

  typedef struct {
    logic [9:0] mask;   // bit i = pulse in window cycle i+1
    int         exp;
  } win_t;

  win_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    tbl[0] = '{10'b1000000001, 2};
    tbl[1] = '{10'b0000000001, 1};
    tbl[2] = '{10'b0000010101, 3};
    tbl[3] = '{10'b1111111111, 10};
    tbl[4] = '{10'b0000000000, 0};
    tbl[5] = '{10'b0101010101, 5};

    rst_n = 1'b0; pulse = 1'b0; enable = 1'b0; count_ready = 1'b1;
    s_pulse = 1'b0; s_enable = 1'b0; s_ready = 1'b1;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_valid", count_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_err, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back windows; pulse on the enable-sample cycle must not count.
    enable = 1'b1; pulse = 1'b1;
    tick();
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 10; i++) begin
        pulse = tbl[w].mask[i];
        tick();
        if (i == 0) begin
          chk($sformatf("win%0d_busy", w), busy, 1);
          chk($sformatf("win%0d_vld_lo", w), count_valid, 0);
        end
      end
      chk($sformatf("win%0d_valid", w), count_valid, 1);
      chk($sformatf("win%0d_count", w), count, tbl[w].exp);
      chk($sformatf("win%0d_sat", w), sat, 0);
    end
    pulse = 1'b0; enable = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid_drained", count_valid, 0);

    // Backpressure: second result dropped, first held.
    count_ready = 1'b0; enable = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin pulse = (i < 4); tick(); end
    chk("bp1_valid", count_valid, 1);
    chk("bp1_count", count, 4);
    chk("bp1_drop", drop_err, 0);
    for (int i = 0; i < 10; i++) begin pulse = (i >= 3); tick(); end
    chk("bp2_count", count, 4);
    chk("bp2_drop", drop_err, 1);
    pulse = 1'b0; enable = 1'b0;
    tick();
    chk("bp_drop_sticky", drop_err, 1);
    count_ready = 1'b1;
    tick();
    chk("bp_hs_valid", count_valid, 0);
    chk("bp_drop_clr", drop_err, 0);
    chk("bp_stale_count", count, 4);

    // Abort at window cycle 5 after 2 pulses, then a clean window.
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin pulse = (i == 1 || i == 2); tick(); end
    pulse = 1'b0; enable = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (count_valid) chk("abort_no_valid", count_valid, 0);
    end
    chk("abort_valid", count_valid, 0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin pulse = (i == 4); tick(); end
    chk("reen_early", count_valid, 0);
    pulse = 1'b0;
    tick();
    chk("reen_valid", count_valid, 1);
    chk("reen_count", count, 1);

    // Reset mid-window with a result held.
    count_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin pulse = 1'b1; tick(); end
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("mrst_count", count, 0);
    chk("mrst_valid", count_valid, 0);
    chk("mrst_sat", sat, 0);
    chk("mrst_drop", drop_err, 0);
    chk("mrst_busy", busy, 0);
    rst_n = 1'b1; enable = 1'b0; pulse = 1'b0; count_ready = 1'b1;
    tick();

    // Saturation on the narrow instance, then exactly full-scale unclamped.
    s_enable = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin s_pulse = 1'b1; tick(); end
    chk("sat_valid", s_valid, 1);
    chk("sat_count", s_count, 15);
    chk("sat_flag", s_sat, 1);
    for (int i = 0; i < 20; i++) begin s_pulse = (i < 15); tick(); end
    chk("full_count", s_count, 15);
    chk("full_sat", s_sat, 0);
    chk("full_drop", s_drop, 0);
    s_enable = 1'b0; s_pulse = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gate_counter.md
# pulse_gate_counter

Gated event counter downstream of the rising-edge detector. It counts single-cycle `pulse` events over a fixed window of `GATE_CYCLES` clocks and latches each window total into an output register. The register is drained through a valid/ready handshake. Windows run back-to-back while enabled, giving a periodic event-rate (frequency) measurement.

## Interface
- `CNT_W`, default 16: width of the count and result.
- `GATE_CYCLES`, default 1000: window length in clocks; legal range 2 to 2^24-1.
- `GATE_W`, default 24: width of the gate timer; must satisfy GATE_CYCLES ≤ 2^GATE_W-1.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `pulse`  in  1: event strobe from the edge detector; every high cycle counts as one event.
- `enable`  in  1: level; high runs windows continuously, low aborts and idles.
- `count`  out  CNT_W: latched window total.
- `sat`  out  1: `count` was clamped at 2^CNT_W-1; qualified by `count_valid`.
- `count_valid`  out  1: result register full.
- `count_ready`  in  1: consumer accepts the result when `count_valid` and `count_ready` are both high.
- `drop_err`  out  1: sticky; a finished window's result was discarded because the register was full.
- `busy`  out  1: high while a window is in progress.

## Operation
- The FSM has two states, IDLE and GATE.
- **IDLE:**
  - The timer and accumulator are held at 0 and `busy` is 0.
  - `enable` sampled high moves the FSM to GATE on the next edge.
  - `drop_err` clears on any cycle spent in IDLE.
- **GATE:**
  - The timer runs 0 to GATE_CYCLES-1, one step per cycle.
  - The accumulator adds `pulse` each cycle and saturates at 2^CNT_W-1, setting an internal sat bit.
  - `busy` is 1.
- **Last window cycle** (timer = GATE_CYCLES-1):
  - The final total is acc + pulse, saturated.
  - If `count_valid` is 0, or the handshake fires in that same cycle, the register loads `count`/`sat` and `count_valid` is 1 (or stays 1).
  - Otherwise the total is discarded, `drop_err` is set, and the held result is unchanged.
  - The timer and accumulator restart from 0.
  - If `enable` is still high, the next window starts on the following cycle with no gap; otherwise the FSM returns to IDLE.
- **`enable` low mid-window:** the window aborts. The FSM returns to IDLE on the next edge, no result is produced and the partial count is discarded. A result already held stays held.
- **Output register:** holds its value until the handshake fires. The handshake with no new load clears `count_valid`; `count`/`sat` keep their stale values.
- **Reset:** `rst_n` low at any edge, including mid-window, forces IDLE. The timer and accumulator go to 0. All outputs go to 0: `count`=0, `sat`=0, `count_valid`=0, `drop_err`=0, `busy`=0.

## Timing
- Enable sampled high in IDLE at edge E: window cycles are E+1 to E+GATE_CYCLES. A pulse in cycle E is not counted.
- Result latency: `count_valid` rises at the edge ending the window's last cycle, so it is visible in the first cycle after the window.
- Back-to-back windows are exactly GATE_CYCLES apart. A pulse in the last cycle of window N belongs to N; a pulse in the first cycle of window N+1 belongs to N+1.
- Handshake is a single cycle. `count_ready` may be held high permanently, in which case no results are ever dropped.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `pc_utils_pkg` holds:
  - the state enum (IDLE, GATE);
  - default constants `PC_CNT_W`=16 and `PC_GATE_W`=24.
- Sub-module `gate_timer` (parameters GATE_CYCLES, GATE_W; inputs `clk`, `rst_n`, `run`; output `last`). It is a wrap-around counter that asserts `last` when the count equals GATE_CYCLES-1 and holds at 0 when `run` is 0.
- The top level holds the FSM, the saturating accumulator, the result register and the handshake.

## Test plan
1. **Basic count:** GATE_CYCLES=10, `count_ready`=1; enable high, 3 pulses inside the window → `count`=3, `sat`=0, `count_valid` high for 1 cycle, 11 cycles after enable sampled.
2. **Saturation:** CNT_W=4, `pulse` held high for a full 20-cycle window → `count`=15, `sat`=1.
3. **Window boundaries:** pulse on the enable cycle, first window cycle, and last window cycle of window 1, plus the first cycle of window 2 → window 1 result `count`=2, window 2 result `count`=1.
4. **Backpressure:** `count_ready`=0 across two windows with 4 then 7 pulses → `count`=4 held, `drop_err`=1 after the second window ends; `count_ready` pulsed → `count_valid` falls.
5. **Abort:** enable dropped at window cycle 5 with 2 pulses counted → no `count_valid`; re-enable with 1 pulse → `count`=1.
6. **Reset mid-window:** `rst_n`=0 for 1 cycle with a result held and a window active → next cycle all outputs are 0 and `busy`=0.
